// File: rtl/hex_display_pkg.sv
// Shared types and segment constants for the multi-digit seven-segment driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package hex_display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/hex_display_driver_seg7_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module seg7_decode
   import hex_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/hex_display_driver.sv
// Latches a value on load and renders it on DIGITS seven-segment displays in hex
// or decimal (double-dabble), with leading-zero blanking, overflow dashes and blink.
module hex_display_driver
   import hex_display_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int DIGITS    = 6,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [WIDTH-1:0]      value,
   input  logic                  dec_mode,
   input  logic                  blank_lz,
   input  logic                  blink_en,
   output logic                  busy,
   output logic                  overflow,
   output logic [DIGITS*7-1:0]   segs
);

   localparam int BW    = DIGITS * 4;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   // Handshake: load is taken only in a cycle where busy=0; busy stays high until
   // the edge that publishes segs/overflow, and a load the very next cycle is taken.
   state_t              state;
   logic [WIDTH-1:0]    bin;
   logic [BW-1:0]       bcd;
   logic [BW-1:0]       bcd_adj;
   logic [BW-1:0]       value_ext;
   logic [CNT_W-1:0]    shift_cnt;
   logic                blz_r;
   logic                ovf_r;
   logic                hex_ovf;
   logic                leading;
   logic [DIGITS*7-1:0] seg_dec;
   logic [DIGITS*7-1:0] seg_next;
   logic [DIGITS*7-1:0] seg_reg;
   logic [BLK_W-1:0]    blink_cnt;
   logic                blink_on;

   generate
      if (WIDTH > BW) begin : g_wide
         assign value_ext = value[BW-1:0];
         assign hex_ovf   = |value[WIDTH-1:BW];
      end else begin : g_narrow
         assign value_ext = BW'(value);
         assign hex_ovf   = 1'b0;
      end
   endgenerate

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // The bcd register doubles as the hex digit store, so one decoder bank serves both modes.
   for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      seg7_decode u_dec (
         .nibble (bcd[4*g +: 4]),
         .seg    (seg_dec[7*g +: 7])
      );
   end

   always_comb begin
      leading  = 1'b1;
      seg_next = seg_dec;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (bcd[4*i +: 4] != 4'd0) leading = 1'b0;
         if (ovf_r)                              seg_next[7*i +: 7] = SEG_DASH;
         else if (blz_r && leading && (i != 0))  seg_next[7*i +: 7] = SEG_BLANK;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bin       <= '0;
         bcd       <= '0;
         shift_cnt <= '0;
         blz_r     <= 1'b0;
         ovf_r     <= 1'b0;
         busy      <= 1'b0;
         overflow  <= 1'b0;
         seg_reg   <= {DIGITS{SEG_BLANK}};
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  blz_r     <= blank_lz;
                  shift_cnt <= '0;
                  busy      <= 1'b1;
                  if (dec_mode) begin
                     bin   <= value;
                     bcd   <= '0;
                     ovf_r <= 1'b0;
                     state <= SHIFT;
                  end else begin
                     bcd   <= value_ext;
                     ovf_r <= hex_ovf;
                     state <= DONE;
                  end
               end
            end
            SHIFT: begin
               ovf_r       <= ovf_r | bcd_adj[BW-1];
               {bcd, bin}  <= {bcd_adj[BW-2:0], bin, 1'b0};
               shift_cnt   <= shift_cnt + 1'b1;
               if (shift_cnt == CNT_W'(WIDTH - 1)) state <= DONE;
            end
            DONE: begin
               seg_reg  <= seg_next;
               overflow <= ovf_r;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         blink_on  <= ~blink_on;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   // Blink gating sits after the register so blink_en acts in the same cycle.
   assign segs = (blink_en && !blink_on) ? {DIGITS{SEG_BLANK}} : seg_reg;

endmodule

// File: tb/tb_hex_display_driver.sv
// Randomized self-checking bench for hex_display_driver against an arithmetic
// reference model (digits by division, overflow by range, blink by edge count).
module tb_hex_display_driver;

   localparam int WIDTH     = 32;
   localparam int DIGITS    = 6;
   localparam int BLINK_DIV = 4;
   localparam int SW        = DIGITS * 7;
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] DASH  = 7'b0111111;

   logic             clk;
   logic             rst_n;
   logic             load;
   logic [WIDTH-1:0] value;
   logic             dec_mode;
   logic             blank_lz;
   logic             blink_en;
   logic             busy;
   logic             overflow;
   logic [SW-1:0]    segs;

   int total = 0;
   int bad   = 0;
   int mdl_edges;
   logic [SW-1:0] exp_segs;
   logic          exp_ovf;

   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   hex_display_driver #(
      .WIDTH     (WIDTH),
      .DIGITS    (DIGITS),
      .BLINK_DIV (BLINK_DIV)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .value    (value),
      .dec_mode (dec_mode),
      .blank_lz (blank_lz),
      .blink_en (blink_en),
      .busy     (busy),
      .overflow (overflow),
      .segs     (segs)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mdl_edges <= 0;
      else        mdl_edges <= mdl_edges + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reference: digits by repeated division, overflow when value exceeds the digit range.
   function automatic void model(input logic [31:0] v, input bit dec, input bit blz,
                                 output logic [SW-1:0] s, output logic ovf);
      longint unsigned base, x, lim;
      int d [DIGITS];
      int top;
      base = dec ? 10 : 16;
      x    = longint'(v);
      lim  = 1;
      for (int i = 0; i < DIGITS; i++) lim = lim * base;
      ovf = (x >= lim);
      top = 0;
      for (int i = 0; i < DIGITS; i++) begin
         d[i] = int'(x % base);
         x    = x / base;
         if (d[i] != 0) top = i;
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (ovf)                 s[7*i +: 7] = DASH;
         else if (blz && i > top) s[7*i +: 7] = BLANK;
         else                     s[7*i +: 7] = seg_tab[d[i]];
      end
   endfunction

   function automatic logic [SW-1:0] visible(input logic [SW-1:0] s);
      if (blink_en && ((mdl_edges / BLINK_DIV) % 2) == 1) return {DIGITS{BLANK}};
      return s;
   endfunction

   // driver task: called at a negedge, returns at the negedge where busy fell
   task automatic do_load(input string tag, input logic [31:0] v, input bit dec,
                          input bit blz, input int intrude_at);
      int n;
      logic [SW-1:0] es;
      logic eo;
      value = v; dec_mode = dec; blank_lz = blz; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         if (n == intrude_at) begin
            value = 32'h00FF_FFFF; dec_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      load = 1'b0;
      check_eq({tag, " busy_cycles"}, 64'(n), dec ? 64'd33 : 64'd1);
      model(v, dec, blz, es, eo);
      exp_segs = es;
      exp_ovf  = eo;
      check_eq({tag, " segs"}, 64'(segs), 64'(visible(exp_segs)));
      check_eq({tag, " overflow"}, 64'(overflow), 64'(exp_ovf));
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; value = '0; dec_mode = 1'b0;
      blank_lz = 1'b0; blink_en = 1'b0;
      exp_segs = {DIGITS{BLANK}};
      exp_ovf  = 1'b0;

      repeat (3) @(negedge clk);
      check_eq("rst segs", 64'(segs), 64'({DIGITS{BLANK}}));
      check_eq("rst busy", 64'(busy), 64'd0);
      check_eq("rst overflow", 64'(overflow), 64'd0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check_eq("idle segs", 64'(segs), 64'({DIGITS{BLANK}}));
      check_eq("idle busy", 64'(busy), 64'd0);
      check_eq("idle overflow", 64'(overflow), 64'd0);

      do_load("hex_beef", 32'h0000_BEEF, 1'b0, 1'b1, 0);
      do_load("dec_999999", 32'd999999, 1'b1, 1'b0, 0);
      do_load("dec_zero_blz", 32'd0, 1'b1, 1'b1, 0);
      do_load("dec_ovf", 32'd1000000, 1'b1, 1'b0, 0);
      do_load("hex_ovf", 32'h0100_0000, 1'b0, 1'b0, 0);
      do_load("hex_5", 32'h5, 1'b0, 1'b1, 0);
      do_load("dec_max", 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
      do_load("hex_top_fit", 32'h00FF_FFFF, 1'b0, 1'b1, 0);
      do_load("load_in_busy", 32'd123456, 1'b1, 1'b0, 5);

      // blink: gating is immediate on blink_en and toggles every BLINK_DIV edges
      blink_en = 1'b1;
      #1;
      check_eq("blink enable", 64'(segs), 64'(visible(exp_segs)));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_eq("blink phase", 64'(segs), 64'(visible(exp_segs)));
      end
      @(negedge clk);
      blink_en = 1'b0;
      #1;
      check_eq("blink off", 64'(segs), 64'(exp_segs));

      // reset in the middle of a decimal conversion
      @(negedge clk);
      value = 32'd654321; dec_mode = 1'b1; blank_lz = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (9) @(negedge clk);
      check_eq("mid busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      exp_segs = {DIGITS{BLANK}};
      exp_ovf  = 1'b0;
      check_eq("abort segs", 64'(segs), 64'(exp_segs));
      check_eq("abort busy", 64'(busy), 64'd0);
      check_eq("abort overflow", 64'(overflow), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_load("after_rst", 32'd654321, 1'b1, 1'b1, 0);

      // randomized loads, back-to-back, mixing ranges to hit both overflow edges
      for (int i = 0; i < 40; i++) begin
         logic [31:0] v;
         case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = $urandom % 1_000_000;
            2:       v = $urandom_range(0, 20);
            default: v = $urandom & 32'h01FF_FFFF;
         endcase
         do_load("rand", v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hex_display_driver.md
# hex_display_driver

Parametrised multi-digit seven-segment driver for the DE1-SoC HEX displays. Latches a binary value on a load strobe and renders it in hexadecimal or decimal, with optional leading-zero blanking, overflow indication and display blinking. Decimal conversion is an iterative shift-add-3 (double-dabble) engine, so the block has a busy/load handshake. It sits between datapath status registers and the HEX0..HEXn pins.

## Interface
- WIDTH, 32: bit width of the input value.
- DIGITS, 6: number of seven-segment digits driven.
- BLINK_DIV, 25_000_000: clock cycles per blink half-period; minimum 1.
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- load  input  1  single-cycle strobe; sampled only when busy=0.
- value  input  WIDTH  number to display; captured on accepted load.
- dec_mode  input  1  1 = decimal, 0 = hexadecimal; captured with value.
- blank_lz  input  1  1 = blank leading zero digits; captured with value.
- blink_en  input  1  1 = blink whole display; live, not captured.
- busy  output  1  high while a conversion is in progress.
- overflow  output  1  high while the displayed value did not fit in DIGITS digits.
- segs  output  DIGITS*7  active-low segments; digit i at segs[7i+6:7i], bit order {g,f,e,d,c,b,a}; digit 0 least significant.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: load=1 captures value, dec_mode, blank_lz; dec_mode=0 -> DONE, dec_mode=1 -> SHIFT with shift count 0 and BCD register (DIGITS*4 bits) cleared.
- SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one. Any 1 shifted out of the BCD MSB sets a sticky overflow flag. After WIDTH shifts -> DONE.
- HEX overflow: any 1 in value[WIDTH-1:DIGITS*4]. When WIDTH <= DIGITS*4, zero-extend and never overflow.
- DONE: decode digits, register segs and overflow, then -> IDLE.
- Overflow display: every digit shows dash 7'b0111111.
- Leading-zero blanking: zero digits above the highest non-zero digit show 7'b1111111. Digit 0 is always shown. Blanking does not apply under overflow.
- Blink: a free-running counter toggles the blink phase every BLINK_DIV cycles. While blink_en=1 and phase=off, segs outputs are all 7'b1111111. The phase gating is combinational on the registered segs, so blink_en takes effect the same cycle. The stored display is unaffected.
- load while busy=1 is ignored, with no queueing. segs holds the previous value until DONE.

## Timing
- Reset values: segs all 7'b1111111, busy 0, overflow 0, state IDLE, blink counter 0, blink phase on.
- Load accepted at edge k.
  - HEX: busy=1 for one cycle; segs and overflow update at edge k+1.
  - DEC: busy=1 for WIDTH+1 cycles; segs and overflow update at edge k+WIDTH+1.
- busy falls at the same edge that segs updates. A load in the following cycle is accepted.
- rst_n low mid-conversion aborts immediately to reset values, including blanking the display.
- The blink counter runs in every state and is not reset by load.

## Structure
- Package hex_display_pkg holds:
  - the state enum;
  - SEG_BLANK (7'b1111111) and SEG_DASH (7'b0111111);
  - the 16-entry hex-to-segment constant: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Sub-module seg7_decode: combinational 4-bit nibble to 7-bit active-low segments. Instantiated DIGITS times.
- Top holds the FSM, the double-dabble datapath, the blanking/overflow mux and the blink counter.

## Test plan
All with WIDTH=32, DIGITS=6, BLINK_DIV=4.
- Reset: rst_n low -> segs all 7'b1111111, busy 0, overflow 0. Release, then idle 10 cycles -> unchanged.
- HEX 32'h0000BEEF, blank_lz=1 -> busy high exactly 1 cycle. Digits 5,4 = 1111111; digits 3..0 = 0000011, 0000110, 0000110, 0001110; overflow 0.
- DEC 999999, blank_lz=0 -> busy high exactly 33 cycles, then all digits 0010000. Then DEC 0, blank_lz=1 -> digit 0 = 1000000, digits 5..1 blank.
- Overflow: DEC 1000000 -> all digits 0111111, overflow 1. HEX 32'h01000000 -> the same. Then HEX 32'h5 -> overflow 0.
- Load during busy: DEC 123456, then load HEX 32'hFFFFFF at cycle 5 -> second load ignored; display 123456 after 33 cycles.
- Blink and reset:
  - blink_en=1 -> segs alternate between stored pattern and all-blank every 4 cycles.
  - rst_n pulsed low at cycle 10 of a DEC conversion -> immediate reset values, busy 0.
  - A new load after reset completes normally.
